// File: rtl/jtcps1_obj_line_pkg.sv
// Shared constants, FSM states and helpers for the CPS1 per-line object table builder.
// Field positions cover both the frame-table attribute word and the line-entry words.
package jtcps1_obj_line_pkg;

    localparam logic [15:0] END_MARK    = 16'hFF00;
    localparam int          ENTRIES_DEF = 113;
    localparam logic [8:0]  BLANK_X_DEF = 9'd480;

    localparam int ATTR_NY_LSB  = 12;
    localparam int ATTR_NX_LSB  = 8;
    localparam int ATTR_VFLIP   = 6;
    localparam int ATTR_HFLIP   = 5;
    localparam int ATTR_PAL_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CHECK,
        ST_EMIT,
        ST_NEXT,
        ST_FILL,
        ST_DONE
    } state_t;

    function automatic logic [15:0] make_e0(input logic [3:0] vsub, input logic hflip,
                                            input logic [4:0] pal);
        make_e0 = {4'd0, vsub, 2'd0, hflip, pal};
    endfunction

    // Column offset wraps inside the low nibble; the row offset carries into the upper bits.
    function automatic logic [15:0] tile_code(input logic [15:0] code, input logic [3:0] sc,
                                              input logic [3:0] sr);
        logic [3:0] nib;
        nib       = code[3:0] + sc;
        tile_code = {code[15:4], 4'd0} + {12'd0, nib} + {8'd0, sr, 4'd0};
    endfunction

endpackage

// File: rtl/jtcps1_obj_line_ram.sv
// Double-banked 2x512x16 line table: builder writes the bank not being read,
// drawer reads rd_bank with a one-cycle registered output.
module jtcps1_obj_line_ram (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_bank,
    input  logic        we,
    input  logic [8:0]  waddr,
    input  logic [15:0] wdata,
    input  logic [8:0]  raddr,
    output logic [15:0] rdata
);

    logic [15:0] mem [0:1023];

    always_ff @(posedge clk) begin
        if (we) mem[{~rd_bank, waddr}] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata <= '0;
        else        rdata <= mem[{rd_bank, raddr}];
    end

endmodule

// File: rtl/jtcps1_obj_line.sv
// Per-line object table builder: scans the frame object table, keeps objects hitting
// vrender, expands blocks into 16-pixel tiles and fills the rest of the bank with blanks.
module jtcps1_obj_line
    import jtcps1_obj_line_pkg::*;
#(
    parameter int         ENTRIES = ENTRIES_DEF,
    parameter logic [8:0] BLANK_X = BLANK_X_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [8:0]  vrender,
    output logic [9:0]  frame_addr,
    input  logic [15:0] frame_data,
    input  logic [8:0]  table_addr,
    output logic [15:0] table_data,
    output logic        done
);

    localparam logic [6:0] LAST_IDX = 7'(ENTRIES - 1);

    state_t      state, next_state;
    logic        bank;
    logic [7:0]  obj;
    logic [1:0]  word;
    logic [3:0]  col;
    logic [6:0]  wr_idx;
    logic [8:0]  obj_x, obj_y;
    logic [15:0] obj_code;
    logic [3:0]  ny, nx;
    logic        vflip, hflip;
    logic [4:0]  pal;
    logic [7:0]  row;
    logic [8:0]  row_now;
    logic        hit, last_word;
    logic [3:0]  sc, sr, vsub;
    logic [8:0]  tx;
    logic        we;
    logic [8:0]  waddr;
    logic [15:0] wdata;

    assign frame_addr = {obj, word};
    assign last_word  = (word == 2'd3);
    assign row_now    = vrender - obj_y;
    assign hit        = row_now[8:4] <= {1'b0, frame_data[ATTR_NY_LSB +: 4]};
    assign sc         = hflip ? nx - col : col;
    assign sr         = vflip ? ny - row[7:4] : row[7:4];
    assign vsub       = vflip ? ~row[3:0] : row[3:0];
    assign tx         = obj_x + {1'b0, col, 4'd0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // A start pulse in any state restarts the scan; the bank flips regardless.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  next_state = ST_IDLE;
            ST_READ:  if (last_word) next_state = ST_CHECK;
            ST_CHECK: begin
                if (frame_data == END_MARK) next_state = ST_FILL;
                else if (hit)               next_state = ST_EMIT;
                else                        next_state = ST_NEXT;
            end
            ST_EMIT: begin
                if (last_word) begin
                    if (wr_idx == 7'd0)  next_state = ST_DONE;
                    else if (col == nx)  next_state = ST_NEXT;
                end
            end
            ST_NEXT:  next_state = (obj == 8'hFF) ? ST_FILL : ST_READ;
            ST_FILL:  if (last_word && wr_idx == 7'd0) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
        if (start) next_state = ST_READ;
    end

    always_comb begin
        we    = 1'b0;
        done  = 1'b0;
        waddr = {wr_idx, word};
        wdata = 16'd0;
        case (state)
            ST_EMIT: begin
                we = 1'b1;
                case (word)
                    2'd0:    wdata = make_e0(vsub, hflip, pal);
                    2'd1:    wdata = tile_code(obj_code, sc, sr);
                    2'd2:    wdata = {7'd0, tx};
                    default: wdata = 16'd0;
                endcase
            end
            ST_FILL: begin
                we = 1'b1;
                if (word == 2'd2) wdata = {7'd0, BLANK_X};
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Read data trails the address by one cycle, so word k-1 is captured while word k is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank     <= 1'b0;
            obj      <= 8'd0;
            word     <= 2'd0;
            col      <= 4'd0;
            wr_idx   <= LAST_IDX;
            obj_x    <= 9'd0;
            obj_y    <= 9'd0;
            obj_code <= 16'd0;
            ny       <= 4'd0;
            nx       <= 4'd0;
            vflip    <= 1'b0;
            hflip    <= 1'b0;
            pal      <= 5'd0;
            row      <= 8'd0;
        end else if (start) begin
            bank   <= ~bank;
            obj    <= 8'd0;
            word   <= 2'd0;
            col    <= 4'd0;
            wr_idx <= LAST_IDX;
        end else begin
            case (state)
                ST_READ: begin
                    word <= word + 2'd1;
                    case (word)
                        2'd1:    obj_x    <= frame_data[8:0];
                        2'd2:    obj_y    <= frame_data[8:0];
                        2'd3:    obj_code <= frame_data;
                        default: ;
                    endcase
                end
                ST_CHECK: begin
                    ny    <= frame_data[ATTR_NY_LSB +: 4];
                    nx    <= frame_data[ATTR_NX_LSB +: 4];
                    vflip <= frame_data[ATTR_VFLIP];
                    hflip <= frame_data[ATTR_HFLIP];
                    pal   <= frame_data[ATTR_PAL_LSB +: 5];
                    row   <= row_now[7:0];
                    col   <= 4'd0;
                    word  <= 2'd0;
                end
                ST_EMIT: begin
                    word <= word + 2'd1;
                    if (last_word) begin
                        col <= col + 4'd1;
                        if (wr_idx != 7'd0) wr_idx <= wr_idx - 7'd1;
                    end
                end
                ST_NEXT: begin
                    obj  <= obj + 8'd1;
                    word <= 2'd0;
                end
                ST_FILL: begin
                    word <= word + 2'd1;
                    if (last_word && wr_idx != 7'd0) wr_idx <= wr_idx - 7'd1;
                end
                default: ;
            endcase
        end
    end

    jtcps1_obj_line_ram u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_bank (bank),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr   (table_addr),
        .rdata   (table_data)
    );

endmodule

// File: tb/tb_jtcps1_obj_line.sv
// Self-checking bench for jtcps1_obj_line: a list-based model of the line table and build
// latency, checked by reading back each built bank after the next line pulse.
module tb_jtcps1_obj_line;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  vrender = 9'd0;
    logic [9:0]  frame_addr;
    logic [15:0] frame_data = 16'd0;
    logic [8:0]  table_addr = 9'd0;
    logic [15:0] table_data;
    logic        done;

    logic [15:0] fmem [0:1023];
    logic [15:0] exp_tab [0:451];
    int          exp_cycles = 0;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          done_lat = 0;
    int          cyc = 0;
    logic        rd_en = 1'b0;
    logic        chk_v = 1'b0;
    logic [8:0]  chk_a = 9'd0;

    always #5 clk = ~clk;

    jtcps1_obj_line dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .vrender    (vrender),
        .frame_addr (frame_addr),
        .frame_data (frame_data),
        .table_addr (table_addr),
        .table_data (table_data),
        .done       (done)
    );

    always @(posedge clk) frame_data <= fmem[frame_addr];

    always @(posedge clk) begin
        if (start) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_lat = cyc;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    always @(posedge clk) begin
        chk_v <= rd_en;
        chk_a <= table_addr;
    end

    always @(negedge clk) begin
        if (chk_v) checkOutput($sformatf("table[%0d]", chk_a), {16'd0, table_data}, {16'd0, exp_tab[chk_a]});
    end

    task automatic clearFrame();
        for (int k = 0; k < 1024; k++) fmem[k] = (k % 4 == 3) ? 16'hFF00 : 16'h0000;
    endtask

    task automatic setObj(input int o, input int x, input int y, input int code, input int attr);
        fmem[o*4]   = 16'(x);
        fmem[o*4+1] = 16'(y);
        fmem[o*4+2] = 16'(code);
        fmem[o*4+3] = 16'(attr);
    endtask

    // Objects are taken in order; entry index counts down from 112, blanks fill the rest.
    task automatic computeModel(input int vr);
        int x, y, code, attr, row, r, ny, nx, vf, hf, pal, sc, sr, tcode, vsub, tx, idx, n, cy;
        bit stop;
        for (int k = 0; k < 452; k++) exp_tab[k] = (k % 4 == 2) ? 16'd480 : 16'd0;
        n = 0; cy = 0; stop = 0;
        for (int o = 0; o < 256; o++) begin
            x = fmem[o*4] & 511; y = fmem[o*4+1] & 511;
            code = fmem[o*4+2]; attr = fmem[o*4+3];
            cy += 5;
            if (attr == 16'hFF00) break;
            row = (vr - y + 512) % 512;
            r = row / 16;
            ny = (attr >> 12) & 15; nx = (attr >> 8) & 15;
            vf = (attr >> 6) & 1; hf = (attr >> 5) & 1; pal = attr & 31;
            if (r <= ny) begin
                for (int i = 0; i <= nx; i++) begin
                    sc = hf ? nx - i : i;
                    sr = vf ? ny - r : r;
                    tcode = ((code / 16) * 16 + ((code % 16) + sc) % 16 + 16 * sr) % 65536;
                    vsub = vf ? 15 - (row % 16) : row % 16;
                    tx = (x + 16 * i) % 512;
                    idx = 112 - n;
                    exp_tab[idx*4]   = 16'(vsub * 256 + hf * 32 + pal);
                    exp_tab[idx*4+1] = 16'(tcode);
                    exp_tab[idx*4+2] = 16'(tx);
                    exp_tab[idx*4+3] = 16'd0;
                    n++; cy += 4;
                    if (n == 113) begin stop = 1; break; end
                end
            end
            if (stop) break;
            cy += 1;
        end
        if (!stop) cy += 4 * (113 - n);
        exp_cycles = cy;
    endtask

    task automatic applyStimulus(input int vr);
        @(negedge clk);
        vrender = 9'(vr);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int target, input int max_cycles);
        int n;
        n = 0;
        while (done_cnt < target && n < max_cycles) begin
            @(posedge clk); #2;
            n++;
        end
        if (done_cnt < target) begin
            checks++; errors++;
            $display("[TB] FAIL done timeout: got %0d pulses expected %0d", done_cnt, target);
        end else begin
            checkOutput("done pulse width", {31'd0, done}, 32'd0);
        end
    endtask

    task automatic readBank();
        for (int a = 0; a < 452; a++) begin
            @(negedge clk);
            table_addr = 9'(a);
            rd_en = 1'b1;
        end
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    // Build one line, then pulse start again on an empty frame so the built bank can be read.
    task automatic runScenario(input string name, input int vr);
        int base;
        computeModel(vr);
        base = done_cnt;
        applyStimulus(vr);
        waitDone(base + 1, 3000);
        checkOutput({name, " latency"}, done_lat, exp_cycles);
        clearFrame();
        base = done_cnt;
        applyStimulus(0);
        readBank();
        waitDone(base + 1, 3000);
        checkOutput({name, " empty latency"}, done_lat, 32'd457);
    endtask

    task automatic overflowFrame();
        clearFrame();
        for (int o = 0; o < 200; o++) setObj(o, o, 0, o, o % 32);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not end");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        clearFrame();
        repeat (3) @(negedge clk);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset frame_addr", {22'd0, frame_addr}, 32'd0);
        checkOutput("reset table_data", {16'd0, table_data}, 32'd0);
        rst_n = 1'b1;

        clearFrame();
        setObj(0, 100, 50, 16'h1234, 16'h0025);
        runScenario("single", 53);
        checkOutput("single e0", {16'd0, exp_tab[448]}, 32'h0325);
        checkOutput("single e1", {16'd0, exp_tab[449]}, 32'h1234);
        checkOutput("single e2", {16'd0, exp_tab[450]}, 32'd100);
        checkOutput("single blank", {16'd0, exp_tab[2]}, 32'd480);
        checkOutput("single cycles", exp_cycles, 32'd463);

        clearFrame();
        setObj(0, 40, 0, 16'h000E, 16'h1220);
        setObj(1, 200, 0, 16'h00FE, 16'h1220);
        runScenario("block", 20);
        checkOutput("block code0", {16'd0, exp_tab[449]}, 32'h0010);
        checkOutput("block code1", {16'd0, exp_tab[445]}, 32'h001F);
        checkOutput("block code2", {16'd0, exp_tab[441]}, 32'h001E);
        checkOutput("block x2", {16'd0, exp_tab[442]}, 32'd72);
        checkOutput("block e0", {16'd0, exp_tab[448]}, 32'h0420);
        checkOutput("block carry", {16'd0, exp_tab[437]}, 32'h0100);

        clearFrame();
        setObj(0, 10, 30, 16'h0200, 16'h1043);
        runScenario("vflip", 33);
        checkOutput("vflip code", {16'd0, exp_tab[449]}, 32'h0210);
        checkOutput("vflip e0", {16'd0, exp_tab[448]}, 32'h0C03);

        clearFrame();
        setObj(0, 20, 500, 16'h0300, 16'h1001);
        setObj(1, 60, 500, 16'h0400, 16'h0002);
        runScenario("ywrap", 4);
        checkOutput("ywrap e0", {16'd0, exp_tab[448]}, 32'h0001);
        checkOutput("ywrap code", {16'd0, exp_tab[449]}, 32'h0310);
        checkOutput("ywrap hidden", {16'd0, exp_tab[446]}, 32'd480);

        overflowFrame();
        runScenario("overflow", 5);
        checkOutput("overflow last code", {16'd0, exp_tab[1]}, 32'd112);
        checkOutput("overflow last x", {16'd0, exp_tab[2]}, 32'd112);
        checkOutput("overflow cycles", exp_cycles, 32'd1129);

        clearFrame();
        for (int o = 0; o < 256; o++) setObj(o, o, 300, o, 0);
        runScenario("nohit", 0);
        checkOutput("nohit cycles", exp_cycles, 32'd1988);

        // Abort: second start arrives long before the first build could finish.
        overflowFrame();
        computeModel(5);
        base = done_cnt;
        applyStimulus(5);
        repeat (300) @(negedge clk);
        checkOutput("abort no early done", done_cnt, base);
        applyStimulus(5);
        waitDone(base + 1, 3000);
        checkOutput("abort latency", done_lat, exp_cycles);
        checkOutput("abort single done", done_cnt, base + 1);
        clearFrame();
        base = done_cnt;
        applyStimulus(0);
        readBank();
        waitDone(base + 1, 3000);

        // Reset lands in the middle of the first tile write.
        overflowFrame();
        base = done_cnt;
        applyStimulus(5);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset done", {31'd0, done}, 32'd0);
        checkOutput("midreset frame_addr", {22'd0, frame_addr}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("midreset no done", done_cnt, base);
        checkOutput("midreset idle addr", {22'd0, frame_addr}, 32'd0);

        clearFrame();
        setObj(0, 100, 50, 16'h1234, 16'h0025);
        runScenario("after reset", 53);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
